// File: rtl/div_unit.sv
// Multicycle signed divider: restoring shift-subtract on magnitudes, one quotient
// bit per cycle, then a sign-fix cycle that writes quotient to lo and remainder to hi.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       divControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_t;

    localparam logic [1:0]       CMD_START = 2'b01;
    localparam logic [1:0]       CMD_ABORT = 2'b11;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH - 1);

    // Magnitude as unsigned bits: the most negative value maps onto itself, which is
    // exactly its magnitude when read unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH-1:0] neg;
        neg = -v;
        return v[WIDTH-1] ? neg : v;
    endfunction

    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                     input logic           neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_sign_q;
    logic             r_sign_r;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_div0;
    logic             r_done;
    logic             r_busy;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fit;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_dvs};
    assign w_fit      = ~w_diff[WIDTH];
    assign w_rem_next = w_fit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_fit};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_div0   <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_div0 <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (divControl == CMD_START) begin
                        if (b == '0) begin
                            r_div0 <= 1'b1;
                        end else begin
                            r_quo    <= magnitude($signed(a));
                            r_dvs    <= magnitude($signed(b));
                            r_sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                            r_sign_r <= a[WIDTH-1];
                            r_rem    <= '0;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (divControl == CMD_ABORT) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_CNT) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (divControl != CMD_ABORT) begin
                        r_lo   <= cond_negate(r_quo, r_sign_q);
                        r_hi   <= cond_negate(r_rem, r_sign_r);
                        r_done <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign div0 = r_div0;
    assign done = r_done;
    assign busy = r_busy;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multicycle signed 32-bit divider for the datapath, sitting directly downstream of the control unit.
- Consumes divControl plus operands from the A/B registers; produces quotient (lo) and remainder (hi) for the LO/HI registers, and the div0 exception flag that the control unit uses to enter the divide-by-zero state.
- Uses restoring shift-subtract on magnitudes, one quotient bit per cycle, followed by a sign-fix cycle.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- divControl  input  2  command: 00 idle, 01 start signed DIV, 10 reserved (treated as 00), 11 abort.
- a  input  WIDTH  dividend, sampled only on the start edge.
- b  input  WIDTH  divisor, sampled only on the start edge.
- hi  output  WIDTH  remainder, registered.
- lo  output  WIDTH  quotient, registered.
- div0  output  1  one-cycle pulse: divisor was zero.
- done  output  1  one-cycle pulse: hi/lo updated this cycle.
- busy  output  1  high while a division is in progress (CALC or FIX).

Behaviour:
- Reset (reset=0, async): state=IDLE; hi=0, lo=0, div0=0, done=0, busy=0; counter and internal registers cleared. Reset mid-division abandons it with no hi/lo write.
- States: IDLE, CALC, FIX. div0 and done default to 0 every cycle unless set below.
- IDLE, divControl=01, b!=0 (edge E0):
  - latch |a|, |b|, sign_q = a[W-1]^b[W-1], sign_r = a[W-1];
  - clear partial remainder; counter=0; state=CALC; busy=1.
- IDLE, divControl=01, b==0 (edge E0): div0=1 for exactly one cycle; state stays IDLE; hi/lo unchanged; done stays 0.
- IDLE, divControl 00/10/11: no action.
- CALC (edges E1..E32): each edge shifts {rem, quo} left 1, bringing in the next dividend MSB.
  - If shifted rem >= |b|: rem -= |b| and quotient bit = 1; otherwise the bit is 0.
  - counter increments. On the edge where counter == WIDTH-1, state=FIX.
- FIX (edge E33):
  - lo = sign_q ? -quo : quo; hi = sign_r ? -rem : rem;
  - done=1; busy=0; state=IDLE.
  - Result valid from E33 onward; total latency is 33 edges after the start edge.
- Truncation toward zero; remainder takes the dividend's sign.
- Widths: magnitude of 0x80000000 is 0x80000000, taken as unsigned WIDTH bits (no overflow). MIN/-1 yields lo=0x80000000, hi=0 with no exception.
- divControl=01 while busy: ignored; operands are not re-sampled.
- divControl=11 in CALC or FIX: state=IDLE, busy=0 on the next edge; no hi/lo write; no done.
- hi/lo hold their values between divisions; only FIX writes them.
- A new start is accepted on the edge immediately after done (state is IDLE).

Test Plan:
- Reset released, a=7, b=2, divControl=01 for 1 cycle -> busy=1 for 33 cycles; done pulses at E33 with lo=0x00000003, hi=0x00000001.
- a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). a=7, b=0xFFFFFFFE (-2) -> lo=0xFFFFFFFD, hi=0x00000001.
- Preload hi/lo via a prior division; then a=5, b=0 -> div0=1 for one cycle at E0; done never asserts; busy stays 0; hi/lo unchanged.
- a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, done at E33, div0=0.
- Start a=100, b=7; pulse divControl=01 again with a=9, b=3 at cycle 5; drive reset=0 at cycle 10 -> outputs all 0 immediately (async); no done. After release, a=100, b=7 -> lo=14, hi=2.
- Start a=100, b=7; divControl=11 at cycle 20 -> busy=0 next edge; hi/lo retain their previous values; no done pulse.
